// File: rtl/uart_pkg.sv
// Shared UART types and constants: serializer state enum, legal parameter ranges, idle line level.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, stop bits, paced by baud_tick.
// Parity bit is compiled in when UART_TX_PARITY_EN is defined.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int                 IDX_W     = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic               STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;

`ifdef UART_TX_PARITY_EN
  logic parity_q, parity_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = (PARITY_ODD != 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      tx_q    <= IDLE_LEVEL;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    stop_d   = stop_q;
    tx_d     = tx_q;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        // A tick in the capture cycle is deliberately ignored; SYNC waits for the next one.
        tx_d = IDLE_LEVEL;
        if (tx_valid) begin
          shift_d  = tx_data;
          idx_d    = '0;
          stop_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d = (^tx_data) ^ (PARITY_ODD != 0);
`endif
          state_d  = SYNC;
        end
      end
      SYNC: begin
        if (baud_tick) begin
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (baud_tick) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = PARITY;
`else
            tx_d    = IDLE_LEVEL;
            state_d = STOP;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          tx_d    = IDLE_LEVEL;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (baud_tick) begin
          if (stop_q == STOP_LAST) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = IDLE_LEVEL;
      end
    endcase
  end

  assign tx       = tx_q;
  assign tx_ready = (state_q == IDLE);
  assign tx_busy  = (state_q != IDLE);
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: two instances (8N1 even, 8-bit 2-stop odd) against a frame-list model
// plus hand-written per-tick line sequences. Honours UART_TX_PARITY_EN if defined.
module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
  localparam logic [31:0] EXP_A5_A  = 32'b0_10100101_0_1;
  localparam logic [31:0] EXP_A5_B  = 32'b0_10100101_1_11;
  localparam logic [31:0] EXP_00_A  = 32'b0_00000000_0_1;
  localparam logic [31:0] EXP_00_B  = 32'b0_00000000_1_11;
  localparam logic [31:0] EXP_BB_A  = 32'b0_10101010_0_1_0_11110000_0_1;
  localparam logic [31:0] EXP_BB_B  = 32'b0_10101010_1_11_0_11110000_1_11;
  localparam logic [31:0] EXP_3C_A  = 32'b0_00111100_0_1;
  localparam logic [31:0] EXP_3C_B  = 32'b0_00111100_1_11;
`else
  localparam int PB = 0;
  localparam logic [31:0] EXP_A5_A  = 32'b0_10100101_1;
  localparam logic [31:0] EXP_A5_B  = 32'b0_10100101_11;
  localparam logic [31:0] EXP_00_A  = 32'b0_00000000_1;
  localparam logic [31:0] EXP_00_B  = 32'b0_00000000_11;
  localparam logic [31:0] EXP_BB_A  = 32'b0_10101010_1_0_11110000_1;
  localparam logic [31:0] EXP_BB_B  = 32'b0_10101010_11_0_11110000_11;
  localparam logic [31:0] EXP_3C_A  = 32'b0_00111100_1;
  localparam logic [31:0] EXP_3C_B  = 32'b0_00111100_11;
`endif
  localparam int LEN_A = 10 + PB;
  localparam int LEN_B = 11 + PB;
  localparam int STOPS [2] = '{1, 2};
  localparam int ODD   [2] = '{0, 1};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       baud_tick = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic [1:0] tx_w, rdy_w, busy_w, done_w;

  uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));

  uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(1)) dut_b (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit tick_all = 1'b0;
  int tcnt = 0;
  logic tick_edge = 1'b0;

  always @(posedge clk) begin
    #1;
    if (tick_all) begin
      baud_tick = 1'b1;
    end else begin
      tcnt = (tcnt + 1) % 10;
      baud_tick = (tcnt == 0);
    end
  end

  always @(posedge clk) begin
    tick_edge <= baud_tick;
    cyc <= cyc + 1;
  end

  // Model: each accepted word becomes a list of line levels; every tick shows the next one.
  bit m_busy [2];
  bit m_tx   [2];
  bit m_done [2];
  int m_pos  [2];
  int m_len  [2];
  bit m_bits [2][16];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] = 1'b0; m_tx[i] = 1'b1; m_done[i] = 1'b0; m_pos[i] = 0; m_len[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_done[i] = 1'b0;
        if (!m_busy[i]) begin
          if (tx_valid) begin
            m_bits[i][0] = 1'b0;
            for (int b = 0; b < 8; b++) m_bits[i][1+b] = tx_data[b];
            if (PB == 1) m_bits[i][9] = (^tx_data) ^ (ODD[i] == 1);
            for (int s = 0; s < STOPS[i]; s++) m_bits[i][9+PB+s] = 1'b1;
            m_len[i]  = 9 + PB + STOPS[i];
            m_pos[i]  = -1;
            m_busy[i] = 1'b1;
          end
        end else if (baud_tick) begin
          m_pos[i] = m_pos[i] + 1;
          if (m_pos[i] == m_len[i]) begin
            m_busy[i] = 1'b0;
            m_done[i] = 1'b1;
            m_tx[i]   = 1'b1;
          end else begin
            m_tx[i] = m_bits[i][m_pos[i]];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      tests++;
      if ({tx_w[i], rdy_w[i], busy_w[i], done_w[i]} !== {m_tx[i], !m_busy[i], m_busy[i], m_done[i]}) begin
        fails++;
        $display("FAIL cycle_model dut%0d cyc %0d: got tx/rdy/busy/done=%b%b%b%b required %b%b%b%b",
                 i, cyc, tx_w[i], rdy_w[i], busy_w[i], done_w[i], m_tx[i], !m_busy[i], m_busy[i], m_done[i]);
      end
    end
  end

  // Per-tick line log plus event counters, all taken from the DUT outputs.
  bit lg [2][$];
  bit busy_prev [2];
  int done_cnt [2];
  int hs_cnt [2];
  int start_cyc [2];
  int done_cyc [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        busy_prev[i] = 1'b0;
      end else begin
        if (tick_edge && busy_prev[i] && busy_w[i]) begin
          if (lg[i].size() == 0) start_cyc[i] = cyc;
          lg[i].push_back(tx_w[i]);
        end
        if (done_w[i]) begin
          done_cnt[i]++;
          done_cyc[i] = cyc;
        end
        if (tx_valid && rdy_w[i]) hs_cnt[i]++;
        busy_prev[i] = busy_w[i];
      end
    end
  end

  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic check_log(input string name, input int i, input logic [31:0] exp, input int n);
    logic [31:0] g;
    g = '0;
    for (int k = 0; k < lg[i].size(); k++) g = {g[30:0], lg[i][k]};
    tests++;
    if (lg[i].size() != n || g != exp) begin
      fails++;
      $display("FAIL %s: got %0d bits %b required %0d bits %b", name, lg[i].size(), g, n, exp);
    end else begin
      $display("[TB] %s: %0d bits %b ok", name, n, g);
    end
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 2; i++) begin
      lg[i].delete();
      done_cnt[i] = 0;
      hs_cnt[i] = 0;
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timeout waiting on DUT", name);
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!(rdy_w[0] && rdy_w[1]) && n < 400) begin cyc1(); n++; end
    if (n >= 400) timeout(name);
  endtask

  task automatic wait_idle(input string name);
    int n;
    cyc1();
    n = 0;
    while ((busy_w[0] || busy_w[1]) && n < 600) begin cyc1(); n++; end
    if (n >= 600) timeout(name);
    cyc1();
    cyc1();
  endtask

  task automatic send(input logic [7:0] w);
    wait_ready("send_ready");
    tx_data  = w;
    tx_valid = 1'b1;
    cyc1();
    tx_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_tx",    int'(tx_w),   3);
    check("reset_ready", int'(rdy_w),  3);
    check("reset_busy",  int'(busy_w), 0);
    check("reset_done",  int'(done_w), 0);
    cyc1();
    rst = 1'b1;
    cyc1();

    // Single frame 0xA5.
    clear_logs();
    send(8'hA5);
    wait_idle("a5_idle");
    check_log("a5_line_a", 0, EXP_A5_A, LEN_A);
    check_log("a5_line_b", 1, EXP_A5_B, LEN_B);
    check("a5_done_a", done_cnt[0], 1);
    check("a5_done_b", done_cnt[1], 1);
    check("a5_span_a", done_cyc[0] - start_cyc[0], LEN_A * 10);
    check("a5_span_b", done_cyc[1] - start_cyc[1], LEN_B * 10);

    // All-zero word: stop bits stand out clearly.
    clear_logs();
    send(8'h00);
    wait_idle("z_idle");
    check_log("zero_line_a", 0, EXP_00_A, LEN_A);
    check_log("zero_line_b", 1, EXP_00_B, LEN_B);

    // Back-to-back with tx_valid held; data switches once the first word is taken.
    clear_logs();
    wait_ready("bb_ready");
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    cyc1();
    tx_data = 8'h0F;
    n = 0;
    while (!(hs_cnt[0] >= 2 && hs_cnt[1] >= 2) && n < 600) begin cyc1(); n++; end
    if (n >= 600) timeout("bb_second_accept");
    tx_valid = 1'b0;
    wait_idle("bb_idle");
    check_log("b2b_line_a", 0, EXP_BB_A, 2 * LEN_A);
    check_log("b2b_line_b", 1, EXP_BB_B, 2 * LEN_B);
    check("b2b_accepts_a", hs_cnt[0], 2);
    check("b2b_accepts_b", hs_cnt[1], 2);
    check("b2b_done_a", done_cnt[0], 2);
    check("b2b_done_b", done_cnt[1], 2);

    // Reset asserted during data bit 3, checked before any clock edge.
    clear_logs();
    send(8'hA5);
    n = 0;
    while (lg[0].size() < 5 && n < 300) begin cyc1(); n++; end
    if (n >= 300) timeout("mid_reset_reach_bit3");
    repeat (3) cyc1();
    #2;
    rst = 1'b0;
    #1;
    check("async_tx",    int'(tx_w),   3);
    check("async_ready", int'(rdy_w),  3);
    check("async_busy",  int'(busy_w), 0);
    repeat (3) cyc1();
    rst = 1'b1;
    cyc1();
    clear_logs();
    send(8'hA5);
    wait_idle("after_reset_idle");
    check_log("after_reset_line_a", 0, EXP_A5_A, LEN_A);
    check_log("after_reset_line_b", 1, EXP_A5_B, LEN_B);
    check("after_reset_done_a", done_cnt[0], 1);

    // baud_tick held high: one bit per clock.
    tick_all = 1'b1;
    cyc1();
    cyc1();
    clear_logs();
    send(8'h3C);
    wait_idle("fast_idle");
    check_log("fast_line_a", 0, EXP_3C_A, LEN_A);
    check_log("fast_line_b", 1, EXP_3C_B, LEN_B);
    check("fast_done_a", done_cnt[0], 1);
    check("fast_done_b", done_cnt[1], 1);
    check("fast_span_a", done_cyc[0] - start_cyc[0], LEN_A);
    check("fast_span_b", done_cyc[1] - start_cyc[1], LEN_B);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
